fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32 core. It is the consumer end of the branch/jump redirect (PCSrcE, PCTargetE) that the execute stage produces. It owns the PC register, issues single-outstanding requests to instruction memory and absorbs variable memory latency. It drives the fetch-to-decode pipeline register, with stall, flush and redirect-squash handling.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, keeps at most one imem request in flight,
// absorbs variable memory latency and drives the fetch-to-decode register.
module fetch_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = 'h13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] word;
  logic             deliver;

  // PC arithmetic wraps naturally at 2^WIDTH; no alignment is enforced.
  assign pc_plus4  = PCF + WIDTH'(4);
  // A word reaches decode either straight from memory or from the hold buffer,
  // but never while a redirect is squashing this cycle or fetch is stalled.
  assign deliver   = !PCSrcE && !StallF &&
                     (((state == S_WAIT) && imem_valid) || (state == S_HOLD));
  assign word      = (state == S_HOLD) ? hold_q : imem_rdata;
  assign imem_req  = (state == S_ISSUE) && !PCSrcE;
  assign imem_addr = PCF;

  // Request/response FSM, PC register and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_ISSUE;
      PCF    <= RESET_PC;
      hold_q <= '0;
    end else begin
      case (state)
        S_ISSUE: begin
          // Responses are not expected here; any stray imem_valid is ignored.
          if (PCSrcE) PCF   <= PCTargetE;
          else        state <= S_WAIT;
        end
        S_WAIT: begin
          if (PCSrcE) begin
            // Redirect beats the response; if it has not arrived yet it must
            // still be swallowed before a new request can go out.
            PCF   <= PCTargetE;
            state <= imem_valid ? S_ISSUE : S_DISCARD;
          end else if (imem_valid) begin
            if (StallF) begin
              hold_q <= imem_rdata;
              state  <= S_HOLD;
            end else begin
              PCF   <= pc_plus4;
              state <= S_ISSUE;
            end
          end
        end
        S_HOLD: begin
          if (PCSrcE) begin
            PCF   <= PCTargetE;
            state <= S_ISSUE;
          end else if (!StallF) begin
            PCF   <= pc_plus4;
            state <= S_ISSUE;
          end
        end
        S_DISCARD: begin
          // Latest redirect target wins while the stale response is pending.
          if (PCSrcE)     PCF   <= PCTargetE;
          if (imem_valid) state <= S_ISSUE;
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

  // Fetch-to-decode register: squash, then stall, then load, else bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD || PCSrcE) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD <= InstrD;
    end else if (deliver) begin
      InstrD   <= word;
      PCD      <= PCF;
      PCPlus4D <= pc_plus4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

endmodule
